// File: rtl/gemm_pkg.sv
// gemm_pkg
//   Shared constants and types for the GEMM operand path.
//   GEMM_N / GEMM_WIDTH : default lanes per MAC operand and signed element width
//   elem_t              : one signed element
//   vec_t               : one packed operand vector, lane 0 first
//   occ_e               : ping-pong buffer occupancy (EMPTY, ONE, FULL)
package gemm_pkg;

  localparam int GEMM_N     = 8;
  localparam int GEMM_WIDTH = 16;

  typedef logic signed [GEMM_WIDTH-1:0] elem_t;
  typedef elem_t [0:GEMM_N-1] vec_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/vec_pingpong_buf.sv
// vec_pingpong_buf
//   Two operand buffers used ping-pong style. The writer fills the buffer at
//   wr_ptr lane by lane and commits it with push; the reader drains the buffer
//   at rd_ptr in commit order through the vec_valid/vec_ready handshake.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     lane_we, lane_clr     : per-lane write / zero strobes into the fill buffer
//     wr_a, wr_b            : element pair written to every lane with lane_we set
//     push, push_last       : commit the fill buffer and its dot-product-end flag
//     in_ready              : low only while both buffers wait to be accepted
//     buf_empty             : no committed buffer is pending
//     vec_valid, vec_ready  : output vector handshake
//     vector_A, vector_B    : committed operands of the oldest buffer
//     vec_last              : oldest buffer closes a dot product
module vec_pingpong_buf
  import gemm_pkg::*;
#(
  parameter int N     = GEMM_N,
  parameter int WIDTH = GEMM_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   lane_we,
  input  logic [N-1:0]                   lane_clr,
  input  logic [WIDTH-1:0]               wr_a,
  input  logic [WIDTH-1:0]               wr_b,
  input  logic                           push,
  input  logic                           push_last,
  output logic                           in_ready,
  output logic                           buf_empty,
  output logic                           vec_valid,
  input  logic                           vec_ready,
  output logic signed [0:N-1][WIDTH-1:0] vector_A,
  output logic signed [0:N-1][WIDTH-1:0] vector_B,
  output logic                           vec_last
);

  occ_e occ, occ_next;
  logic wr_ptr, rd_ptr;
  logic pop;
  logic [1:0] last_q;
  logic [0:N-1][WIDTH-1:0] buf_a [2];
  logic [0:N-1][WIDTH-1:0] buf_b [2];

  assign vec_valid = (occ != OCC_EMPTY);
  assign buf_empty = (occ == OCC_EMPTY);
  assign in_ready  = (occ != OCC_FULL);
  assign pop       = vec_valid && vec_ready;

  // The read side always presents the oldest committed buffer. That buffer is
  // never the write target, so the outputs stay stable while stalled.
  assign vector_A = buf_a[rd_ptr];
  assign vector_B = buf_b[rd_ptr];
  assign vec_last = last_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= OCC_EMPTY;
    end else begin
      occ <= occ_next;
    end
  end

  // Occupancy: a commit and a pop in the same cycle cancel out. A push while
  // FULL cannot happen because in_ready is low there.
  always_comb begin
    occ_next = occ;
    unique case (occ)
      OCC_EMPTY: if (push) occ_next = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_next = OCC_FULL;
        else if (pop && !push) occ_next = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_next = OCC_ONE;
      default:   occ_next = OCC_EMPTY;
    endcase
  end

  // Lane writes land in the fill buffer; lanes that are neither written nor
  // cleared keep whatever that buffer held from its previous use.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      last_q <= '0;
      for (int k = 0; k < 2; k++) begin
        buf_a[k] <= '0;
        buf_b[k] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (lane_we[i]) begin
          buf_a[wr_ptr][i] <= wr_a;
          buf_b[wr_ptr][i] <= wr_b;
        end else if (lane_clr[i]) begin
          buf_a[wr_ptr][i] <= '0;
          buf_b[wr_ptr][i] <= '0;
        end
      end
      if (push) begin
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: rtl/vec_operand_packer.sv
// vec_operand_packer
//   Packs a stream of scalar signed element pairs into N-lane operand vectors
//   for vec_mac. Lane 0 holds the first pair received. A vector is committed
//   when lane N-1 is written or when in_last arrives early (a short vector).
//   Configuration macro VEC_PACK_ZERO_PAD_EN:
//     defined   : short vectors have their unwritten lanes zeroed, err_align stays 0
//     undefined : short vectors keep stale lanes and set err_align until rst
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     in_valid, in_ready    : scalar pair handshake
//     in_a, in_b, in_last   : operand pair and end-of-dot-product marker
//     vec_valid, vec_ready  : vector handshake toward vec_mac
//     vector_A, vector_B    : packed operands
//     vec_last              : vector closes a dot product
//     err_align             : sticky short-vector flag
//     busy                  : any buffer occupied or a vector partly filled
module vec_operand_packer
  import gemm_pkg::*;
#(
  parameter int N     = GEMM_N,
  parameter int WIDTH = GEMM_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WIDTH-1:0]        in_a,
  input  logic signed [WIDTH-1:0]        in_b,
  input  logic                           in_last,
  output logic                           vec_valid,
  input  logic                           vec_ready,
  output logic signed [0:N-1][WIDTH-1:0] vector_A,
  output logic signed [0:N-1][WIDTH-1:0] vector_B,
  output logic                           vec_last,
  output logic                           err_align,
  output logic                           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] fill_idx;
  logic          fire;
  logic          at_end;
  logic          commit;
  logic          short_commit;
  logic          buf_empty;
  logic [N-1:0]  lane_we;
  logic [N-1:0]  lane_clr;

  assign fire         = in_valid && in_ready;
  assign at_end       = (fill_idx == IW'(N - 1));
  assign commit       = fire && (at_end || in_last);
  assign short_commit = fire && in_last && !at_end;
  assign busy         = !buf_empty || (fill_idx != '0);

  // One-hot lane strobe for the pair being transferred, plus the zero mask
  // for lanes beyond it when a short vector is padded.
  always_comb begin
    lane_we  = '0;
    lane_clr = '0;
    for (int i = 0; i < N; i++) begin
      lane_we[i] = fire && (fill_idx == IW'(i));
`ifdef VEC_PACK_ZERO_PAD_EN
      lane_clr[i] = short_commit && (IW'(i) > fill_idx);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_idx <= '0;
    end else if (commit) begin
      fill_idx <= '0;
    end else if (fire) begin
      fill_idx <= fill_idx + IW'(1);
    end
  end

`ifdef VEC_PACK_ZERO_PAD_EN
  assign err_align = 1'b0;
`else
  // A short vector is still emitted, but the misalignment is remembered.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_align <= 1'b0;
    end else if (short_commit) begin
      err_align <= 1'b1;
    end
  end
`endif

  vec_pingpong_buf #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .lane_we   (lane_we),
    .lane_clr  (lane_clr),
    .wr_a      (in_a),
    .wr_b      (in_b),
    .push      (commit),
    .push_last (in_last),
    .in_ready  (in_ready),
    .buf_empty (buf_empty),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vector_A  (vector_A),
    .vector_B  (vector_B),
    .vec_last  (vec_last)
  );

endmodule

// File: tb/tb_vec_operand_packer.sv
// tb_vec_operand_packer
//   Scoreboard bench for vec_operand_packer. The stimulus side predicts each
//   vector from the packing rules and queues it; a separate monitor pops and
//   compares whenever a vector is accepted, and checks output stability while
//   stalled. Expectations follow VEC_PACK_ZERO_PAD_EN when it is defined.
module tb_vec_operand_packer;

  localparam int N = 8;
  localparam int W = 16;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic signed [W-1:0]        in_a = '0;
  logic signed [W-1:0]        in_b = '0;
  logic                       in_last = 1'b0;
  logic                       vec_valid;
  logic                       vec_ready = 1'b0;
  logic signed [0:N-1][W-1:0] vector_A;
  logic signed [0:N-1][W-1:0] vector_B;
  logic                       vec_last;
  logic                       err_align;
  logic                       busy;

  always #5 clk = ~clk;

  vec_operand_packer #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vector_A  (vector_A),
    .vector_B  (vector_B),
    .vec_last  (vec_last),
    .err_align (err_align),
    .busy      (busy)
  );

  typedef struct {
    logic [0:N-1][W-1:0] a;
    logic [0:N-1][W-1:0] b;
    logic                last;
  } exp_t;

  exp_t expQ[$];

  // Reference state: contents of the two ping-pong slots as the rules define
  // them, the count of pairs in the open vector and of commits so far.
  logic [W-1:0] memA [2][N];
  logic [W-1:0] memB [2][N];
  int fillCnt = 0;
  int commitCnt = 0;
  bit errModel = 1'b0;

  int checks = 0;
  int failures = 0;
  int readyMode = 0;
  int popCount = 0;
  logic [0:N-1][W-1:0] lastPopA;
  logic [0:N-1][W-1:0] lastPopB;

  task automatic checkOutput(input string name, input logic [263:0] act, input logic [263:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        memA[k][i] = '0;
        memB[k][i] = '0;
      end
    fillCnt = 0;
    commitCnt = 0;
    errModel = 1'b0;
  endtask

  task automatic modelPush(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int s;
    exp_t e;
    s = commitCnt % 2;
    memA[s][fillCnt] = a;
    memB[s][fillCnt] = b;
    fillCnt++;
    if (last || fillCnt == N) begin
      if (fillCnt < N) begin
`ifdef VEC_PACK_ZERO_PAD_EN
        for (int i = fillCnt; i < N; i++) begin
          memA[s][i] = '0;
          memB[s][i] = '0;
        end
`else
        errModel = 1'b1;
`endif
      end
      for (int i = 0; i < N; i++) begin
        e.a[i] = memA[s][i];
        e.b[i] = memB[s][i];
      end
      e.last = last;
      expQ.push_back(e);
      commitCnt++;
      fillCnt = 0;
    end
  endtask

  // Offer one pair starting just after a falling edge; record it in the model
  // on the edge it transfers. Returns on the falling edge after the transfer.
  task automatic applyStimulus(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input logic last);
    int tries;
    bit done;
    tries = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!done) begin
      #1;
      if (in_ready) begin
        modelPush(a, b, last);
        done = 1'b1;
      end else if (tries >= 200) begin
        checks++;
        failures++;
        $display("[TB] FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", tries);
        done = 1'b1;
      end
      @(negedge clk);
      tries++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic sendRandom(input int count);
    for (int i = 0; i < count; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'b0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || vec_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_empty_and_idle", {expQ.size() == 0, vec_valid}, {1'b1, 1'b0});
  endtask

  // vec_ready pattern generator for the toggling and random phases.
  initial begin
    forever begin
      @(negedge clk);
      if (readyMode == 1) vec_ready = ~vec_ready;
      else if (readyMode == 2) vec_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare accepted vectors against the queue, check stall stability.
  initial begin
    bit prevStall;
    logic [263:0] held;
    exp_t e;
    prevStall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall)
          checkOutput("stall_hold", {vec_valid, vector_A, vector_B, vec_last}, held);
        if (vec_valid && vec_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_vector: got %0h expected none", {vector_A, vector_B, vec_last});
          end else begin
            e = expQ.pop_front();
            checkOutput("vector", {vector_A, vector_B, vec_last}, {e.a, e.b, e.last});
          end
          lastPopA = vector_A;
          lastPopB = vector_B;
          popCount++;
          prevStall = 1'b0;
        end else if (vec_valid) begin
          prevStall = 1'b1;
          held = {1'b1, vector_A, vector_B, vec_last};
        end else begin
          prevStall = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic signed [W-1:0] sa [N];
    logic signed [W-1:0] sb [N];
    int dot;
    sa = '{16'sd5, 16'sd7, 16'sd4, 16'sd1, 16'sd9, 16'sd2, 16'sd3, 16'sd6};
    sb = '{16'sd3, 16'sd2, 16'sd6, 16'sd8, 16'sd0, 16'sd5, 16'sd7, 16'sd4};

    // Reset state
    modelReset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_vec_valid", vec_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_err_align", err_align, 1'b0);
    checkOutput("reset_vec_last", vec_last, 1'b0);

    // Known dot product, single vector, vec_ready high
    $display("[TB] scenario: 8 known pairs");
    vec_ready = 1'b1;
    for (int i = 0; i < N; i++) applyStimulus(sa[i], sb[i], i == N - 1);
    #1;
    checkOutput("known_latency_valid", vec_valid, 1'b1);
    waitDrain();
    dot = 0;
    for (int i = 0; i < N; i++) dot += int'($signed(lastPopA[i])) * int'($signed(lastPopB[i]));
    checkOutput("known_dot_product", dot, 116);

    // Backpressure: two vectors fill both buffers, input stalls
    $display("[TB] scenario: 24 pairs with backpressure");
    vec_ready = 1'b0;
    sendRandom(16);
    #1;
    checkOutput("bp_in_ready_low", in_ready, 1'b0);
    checkOutput("bp_busy", busy, 1'b1);
    in_valid = 1'b1;
    in_a = 16'sd77;
    in_b = -16'sd77;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("bp_still_blocked", in_ready, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    vec_ready = 1'b1;
    sendRandom(8);
    waitDrain();

    // Commit and acceptance on the same edge from one pending vector
    $display("[TB] scenario: simultaneous commit and accept");
    vec_ready = 1'b0;
    sendRandom(8);
    sendRandom(7);
    vec_ready = 1'b1;
    applyStimulus(W'($urandom), W'($urandom), 1'b1);
    #1;
    checkOutput("same_edge_valid", vec_valid, 1'b1);
    checkOutput("same_edge_in_ready", in_ready, 1'b1);
    waitDrain();

    // Continuous stream with vec_ready toggling every cycle
    $display("[TB] scenario: toggling vec_ready");
    readyMode = 1;
    sendRandom(40);
    readyMode = 0;
    @(negedge clk);
    vec_ready = 1'b1;
    waitDrain();

    // Short vector: in_last on the third pair
    $display("[TB] scenario: short vector");
    for (int i = 0; i < 3; i++) applyStimulus(W'($urandom), W'($urandom), i == 2);
    waitDrain();
    checkOutput("short_err_align", err_align, errModel);
    sendRandom(8);
    waitDrain();
    checkOutput("short_err_sticky", err_align, errModel);

    // Reset mid-operation with a committed vector and a partial one
    $display("[TB] scenario: mid-operation reset");
    vec_ready = 1'b0;
    sendRandom(8);
    sendRandom(5);
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 16'sd123;
    in_b = 16'sd45;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("rst_vec_valid", vec_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err_align", err_align, 1'b0);
    @(negedge clk);
    vec_ready = 1'b1;
    sendRandom(8);
    waitDrain();

    // Randomized traffic with random gaps, random in_last and random vec_ready
    $display("[TB] scenario: random traffic");
    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(W'($urandom), W'($urandom), $urandom_range(0, 5) == 0);
    end
    readyMode = 0;
    @(negedge clk);
    vec_ready = 1'b1;
    waitDrain();
    #1;
    checkOutput("final_err_align", err_align, errModel);
    checkOutput("final_busy", busy, fillCnt != 0);
    checkOutput("final_in_ready", in_ready, 1'b1);

    $display("[TB] vectors accepted: %0d", popCount);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_operand_packer.md
VEC_OPERAND_PACKER -- requirements
Module: vec_operand_packer

Interface
REQ-001 SHALL have parameter N, default 8, meaning the vector lanes per MAC operand.
REQ-002 SHALL have parameter WIDTH, default 16, meaning the signed element width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have in_valid/in_ready, input/output, 1 bit each: the scalar element-pair handshake.
REQ-006 SHALL have in_a and in_b, input, WIDTH bits each, signed: the operand pair.
REQ-007 SHALL have in_last, input, 1 bit: marks the final pair of a dot product.
REQ-008 SHALL have vec_valid/vec_ready, output/input, 1 bit each: the vector handshake toward vec_mac.
REQ-009 SHALL have vector_A and vector_B, output, [0:N-1][WIDTH-1:0] signed: the packed operands, with lane 0 the first element received.
REQ-010 SHALL have vec_last, output, 1 bit: the vector closes a dot product.
REQ-011 SHALL have err_align, output, 1 bit: a sticky misalignment flag.
REQ-012 SHALL have busy, output, 1 bit: high when any buffer is occupied or fill_idx is non-zero.

Function
REQ-013 A pair SHALL transfer when in_valid&&in_ready on the rising edge.
REQ-014 A transferred pair SHALL be written to lane fill_idx of the fill buffer, then fill_idx SHALL increment.
REQ-015 The fill buffer SHALL commit when fill_idx==N-1 or in_last is set on a transfer; fill_idx then returns to 0.
REQ-016 A commit SHALL capture vec_last=in_last.
REQ-017 There SHALL be two ping-pong buffers, drained in commit order.
REQ-018 Latency: a commit at cycle t SHALL make vec_valid high at t+1 when the other buffer is empty.
REQ-019 in_ready SHALL be low only while both buffers are committed and unaccepted.
REQ-020 A vector SHALL be accepted on vec_valid&&vec_ready; the buffer then frees on that edge.
REQ-021 A commit and an acceptance in the same cycle SHALL both take effect, with no bubble.
REQ-022 While vec_valid&&!vec_ready, vector_A, vector_B and vec_last SHALL hold stable.
REQ-023 vec_valid SHALL NOT drop until the vector is accepted.
REQ-024 Occupancy states SHALL be EMPTY (0 buffers), ONE (1) and FULL (2).
REQ-025 Occupancy transitions: a commit without a pop SHALL go +1; a pop without a commit SHALL go -1; both together SHALL hold.
REQ-026 A commit SHALL be impossible in FULL, because in_ready is low there.
REQ-027 in_last at fill_idx==N-1 SHALL be aligned, with no error.
REQ-028 The element arithmetic SHALL be pass-through only, with no sign extension or truncation.

Reset
REQ-029 With rst high on an edge: vec_valid, vec_last, err_align, busy and fill_idx SHALL be 0, and both buffers SHALL be cleared to 0.
REQ-030 in_ready SHALL read 1 from the first edge after rst deasserts.
REQ-031 A reset mid-operation SHALL discard partial and committed vectors, with no emission.
REQ-032 An in_valid asserted together with rst SHALL be ignored.

Configuration
REQ-033 Macro VEC_PACK_ZERO_PAD_EN SHALL select how a short commit (in_last with fill_idx<N-1) is handled.
REQ-034 When VEC_PACK_ZERO_PAD_EN is defined: lanes fill_idx+1..N-1 of a short commit SHALL be zeroed, and err_align SHALL stay 0.
REQ-035 When VEC_PACK_ZERO_PAD_EN is undefined: a short commit SHALL still be emitted with unwritten lanes holding their prior contents, and err_align SHALL be set until rst.

Structure
REQ-036 Package gemm_pkg SHALL hold the default N and WIDTH constants, the typedef elem_t (signed WIDTH), the typedef vec_t (elem_t [0:N-1]) and the occupancy enum.
REQ-037 Sub-module vec_pingpong_buf SHALL hold both buffers, the occupancy FSM and the output mux.
REQ-038 The top level SHALL hold fill_idx, lane write-enable and the commit logic.

Verification
REQ-039 Scenario: 8 pairs (5,3)(7,2)(4,6)(1,8)(9,0)(2,5)(3,7)(6,4), last on the 8th, vec_ready=1 -> one vector the cycle after the 8th transfer, lanes in order, vec_last=1, with a dot product of 116 on the downstream MAC.
REQ-040 Scenario: 24 pairs with vec_ready=0 -> in_ready low after the 16th pair; raising vec_ready -> the third vector follows, and order is preserved.
REQ-041 Scenario: vec_ready toggling every cycle during a continuous input stream -> no lost or duplicated vector, and data stable while stalled.
REQ-042 Scenario: in_last on the 3rd pair -> with the macro, lanes 3..7 are 0 and err_align=0; without the macro, err_align=1 and remains set.
REQ-043 Scenario: rst for one cycle after 5 pairs with one vector pending -> no vec_valid, busy=0, and the next 8 pairs form a clean vector.
REQ-044 Scenario: a commit and an acceptance in the same cycle from state ONE -> occupancy stays ONE and vec_valid remains 1.
